// File: rtl/raw2rgb_pkg.sv
// -----------------------------------------------------------------------------
// raw2rgb_pkg
// Shared constants and helpers for the raw Bayer to RGB demosaic path.
//   bayer_phase_e : CFA phase codes ({row,col} XOR applied to coordinate parity)
//   GAIN_UNITY    : Q2.6 white-balance gain value that means 1.0
//   GAIN_FRAC_W   : number of fractional bits in the Q2.6 gain
//   Y_SAT         : value at which the line counter stops incrementing
//   site_code()   : CFA site of a pixel, 00 = red, 11 = blue, 01/10 = green
// -----------------------------------------------------------------------------
package raw2rgb_pkg;

    typedef enum logic [1:0] {
        PH_RGGB = 2'd0,
        PH_GRBG = 2'd1,
        PH_GBRG = 2'd2,
        PH_BGGR = 2'd3
    } bayer_phase_e;

    localparam int          GAIN_UNITY  = 64;
    localparam int          GAIN_FRAC_W = $clog2(GAIN_UNITY);
    localparam logic [10:0] Y_SAT       = 11'd2047;

    // Flipping the row/column parity by the phase bits maps every CFA
    // arrangement onto the RGGB case.
    function automatic logic [1:0] site_code(input logic       y0,
                                             input logic       x0,
                                             input logic [1:0] phase);
        return {y0 ^ phase[1], x0 ^ phase[0]};
    endfunction

endpackage

// File: rtl/line_buf_1.sv
// -----------------------------------------------------------------------------
// line_buf_1
// Single-line pixel store. One port; when enabled, the old word at the address
// is read out (visible the next cycle) and the new word is written in the same
// cycle, so the output is always the previous line's pixel at that column.
// Contents are never reset.
//   i_clk   : clock
//   i_en    : read and write this cycle
//   i_addr  : column address
//   i_wdata : pixel to store
//   o_rdata : pixel previously stored at the last enabled address
// -----------------------------------------------------------------------------
module line_buf_1 #(
    parameter int DEPTH = 640,
    parameter int W     = 10
) (
    input  logic                     i_clk,
    input  logic                     i_en,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [W-1:0]             i_wdata,
    output logic [W-1:0]             o_rdata
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            r_q            <= r_mem[i_addr];
            r_mem[i_addr]  <= i_wdata;
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/raw2rgb_demosaic.sv
// -----------------------------------------------------------------------------
// raw2rgb_demosaic
// Streaming Bayer to RGB converter using a 2x2 kernel built from the current
// pixel, the previous pixel and the matching two pixels of the line above.
// One RGB pixel per accepted raw pixel; latency 2 cycles (3 with gain).
//
// Optional build macro RAW2RGB_WB_GAIN_EN adds white-balance gain ports and a
// third pipeline stage scaling red and blue by Q2.6 gains with saturation.
//
// Ports:
//   VGA_CLK          : clock
//   RST              : synchronous active-high reset
//   iDATA            : raw Bayer pixel
//   iVALID           : iDATA qualified this cycle
//   iSOF             : with iVALID, this pixel is X=0, Y=0
//   iGAIN_R/iGAIN_B  : (macro only) Q2.6 gains for red and blue
//   oRed/oGreen/oBlue: top OUT_W bits of each channel, hold when not valid
//   oVALID           : RGB outputs qualified
//   oX/oY            : coordinates of the newest kernel pixel
//
// Handshake: no back-pressure. A pixel is accepted on every clock with
// iVALID=1 (and RST=0); its result appears exactly LAT clocks later.
// oX/oY update for every accepted pixel, oVALID only inside the valid window.
// -----------------------------------------------------------------------------
module raw2rgb_demosaic
    import raw2rgb_pkg::*;
#(
    parameter int         DATA_W       = 10,
    parameter int         OUT_W        = 8,
    parameter int         ACTIVE_W     = 640,
    parameter logic [1:0] BAYER_PHASE  = PH_RGGB,
    parameter int         VAL_LINE_MIN = 3,
    parameter int         VAL_LINE_MAX = ACTIVE_W - 3
) (
    input  logic                        VGA_CLK,
    input  logic                        RST,
    input  logic [DATA_W-1:0]           iDATA,
    input  logic                        iVALID,
    input  logic                        iSOF,
`ifdef RAW2RGB_WB_GAIN_EN
    input  logic [7:0]                  iGAIN_R,
    input  logic [7:0]                  iGAIN_B,
`endif
    output logic [OUT_W-1:0]            oRed,
    output logic [OUT_W-1:0]            oGreen,
    output logic [OUT_W-1:0]            oBlue,
    output logic                        oVALID,
    output logic [$clog2(ACTIVE_W)-1:0] oX,
    output logic [10:0]                 oY
);

    localparam int XW = $clog2(ACTIVE_W);

    // ---------------- coordinate counters ----------------
    logic [XW-1:0] r_x;
    logic [10:0]   r_y;
    logic [XW-1:0] w_x;
    logic [10:0]   w_y;
    logic          w_acc;
    logic          w_win;

    // r_x/r_y hold the coordinate the next pixel will get; iSOF overrides it.
    assign w_x   = iSOF ? '0 : r_x;
    assign w_y   = iSOF ? '0 : r_y;
    assign w_acc = iVALID & ~RST;
    assign w_win = (w_y != 11'd0) && (int'(w_x) > VAL_LINE_MIN) &&
                   (int'(w_x) < VAL_LINE_MAX);

    always_ff @(posedge VGA_CLK) begin
        if (RST) begin
            r_x <= '0;
            r_y <= '0;
        end else if (iVALID) begin
            if (w_x == XW'(ACTIVE_W - 1)) begin
                r_x <= '0;
                r_y <= (w_y == Y_SAT) ? w_y : w_y + 11'd1;
            end else begin
                r_x <= w_x + XW'(1);
                r_y <= w_y;
            end
        end
    end

    // ---------------- stage 1: kernel ----------------
    logic [DATA_W-1:0] w_lb_q;   // P01: line above, same column
    logic [DATA_W-1:0] r_p11;
    logic [DATA_W-1:0] r_p10;
    logic [DATA_W-1:0] r_p00;
    logic              r_s1_acc;
    logic              r_s1_win;
    logic [XW-1:0]     r_s1_x;
    logic [10:0]       r_s1_y;

    line_buf_1 #(
        .DEPTH (ACTIVE_W),
        .W     (DATA_W)
    ) u_line_buf (
        .i_clk   (VGA_CLK),
        .i_en    (w_acc),
        .i_addr  (w_x),
        .i_wdata (iDATA),
        .o_rdata (w_lb_q)
    );

    // The line-buffer output register only moves on accepted pixels, so its
    // previous value is the upper-left kernel pixel; gaps freeze the kernel.
    always_ff @(posedge VGA_CLK) begin
        if (RST) begin
            r_s1_acc <= 1'b0;
            r_s1_win <= 1'b0;
            r_p11    <= '0;
            r_p10    <= '0;
            r_p00    <= '0;
            r_s1_x   <= '0;
            r_s1_y   <= '0;
        end else begin
            r_s1_acc <= iVALID;
            if (iVALID) begin
                r_p11    <= iDATA;
                r_p10    <= r_p11;
                r_p00    <= w_lb_q;
                r_s1_x   <= w_x;
                r_s1_y   <= w_y;
                r_s1_win <= w_win;
            end
        end
    end

    // ---------------- stage 2: colour mux ----------------
    logic [1:0]        w_c;
    logic [DATA_W:0]   w_gsum_a;   // greens on the anti-diagonal
    logic [DATA_W:0]   w_gsum_b;   // greens on the diagonal
    logic [DATA_W-1:0] w_r_mux;
    logic [DATA_W-1:0] w_g_mux;
    logic [DATA_W-1:0] w_b_mux;

    assign w_c      = site_code(r_s1_y[0], r_s1_x[0], BAYER_PHASE);
    assign w_gsum_a = {1'b0, r_p10} + {1'b0, w_lb_q};
    assign w_gsum_b = {1'b0, r_p11} + {1'b0, r_p00};

    always_comb begin
        w_r_mux = r_p11;
        w_g_mux = w_gsum_a[DATA_W:1];
        w_b_mux = r_p00;
        case (w_c)
            2'b00: begin
                w_r_mux = r_p11;
                w_b_mux = r_p00;
                w_g_mux = w_gsum_a[DATA_W:1];
            end
            2'b11: begin
                w_r_mux = r_p00;
                w_b_mux = r_p11;
                w_g_mux = w_gsum_a[DATA_W:1];
            end
            2'b01: begin
                w_r_mux = r_p10;
                w_b_mux = w_lb_q;
                w_g_mux = w_gsum_b[DATA_W:1];
            end
            2'b10: begin
                w_r_mux = w_lb_q;
                w_b_mux = r_p10;
                w_g_mux = w_gsum_b[DATA_W:1];
            end
            default: begin
                w_r_mux = r_p11;
                w_b_mux = r_p00;
                w_g_mux = w_gsum_a[DATA_W:1];
            end
        endcase
    end

    logic              r_s2_acc;
    logic              r_s2_ok;
    logic [DATA_W-1:0] r_r2;
    logic [DATA_W-1:0] r_g2;
    logic [DATA_W-1:0] r_b2;
    logic [XW-1:0]     r_x2;
    logic [10:0]       r_y2;

    // Colour registers only load for in-window pixels, so they hold otherwise.
    always_ff @(posedge VGA_CLK) begin
        if (RST) begin
            r_s2_acc <= 1'b0;
            r_s2_ok  <= 1'b0;
            r_r2     <= '0;
            r_g2     <= '0;
            r_b2     <= '0;
            r_x2     <= '0;
            r_y2     <= '0;
        end else begin
            r_s2_acc <= r_s1_acc;
            r_s2_ok  <= r_s1_acc & r_s1_win;
            if (r_s1_acc) begin
                r_x2 <= r_s1_x;
                r_y2 <= r_s1_y;
            end
            if (r_s1_acc && r_s1_win) begin
                r_r2 <= w_r_mux;
                r_g2 <= w_g_mux;
                r_b2 <= w_b_mux;
            end
        end
    end

    logic [DATA_W-1:0] w_r_fin;
    logic [DATA_W-1:0] w_g_fin;
    logic [DATA_W-1:0] w_b_fin;

`ifdef RAW2RGB_WB_GAIN_EN
    // ---------------- stage 3: white-balance gain ----------------
    function automatic logic [DATA_W-1:0] apply_gain(input logic [DATA_W-1:0] v,
                                                     input logic [7:0]        g);
        logic [DATA_W+7:0] prod;
        logic [DATA_W+1:0] scaled;
        prod   = {8'd0, v} * {{DATA_W{1'b0}}, g};
        scaled = (DATA_W+2)'(prod >> GAIN_FRAC_W);
        if (scaled > {2'b00, {DATA_W{1'b1}}}) begin
            return '1;
        end
        return scaled[DATA_W-1:0];
    endfunction

    logic              r_s3_ok;
    logic [DATA_W-1:0] r_r3;
    logic [DATA_W-1:0] r_g3;
    logic [DATA_W-1:0] r_b3;
    logic [XW-1:0]     r_x3;
    logic [10:0]       r_y3;

    always_ff @(posedge VGA_CLK) begin
        if (RST) begin
            r_s3_ok <= 1'b0;
            r_r3    <= '0;
            r_g3    <= '0;
            r_b3    <= '0;
            r_x3    <= '0;
            r_y3    <= '0;
        end else begin
            r_s3_ok <= r_s2_ok;
            if (r_s2_acc) begin
                r_x3 <= r_x2;
                r_y3 <= r_y2;
            end
            if (r_s2_ok) begin
                r_r3 <= apply_gain(r_r2, iGAIN_R);
                r_g3 <= r_g2;
                r_b3 <= apply_gain(r_b2, iGAIN_B);
            end
        end
    end

    assign w_r_fin = r_r3;
    assign w_g_fin = r_g3;
    assign w_b_fin = r_b3;
    assign oVALID  = r_s3_ok;
    assign oX      = r_x3;
    assign oY      = r_y3;
`else
    assign w_r_fin = r_r2;
    assign w_g_fin = r_g2;
    assign w_b_fin = r_b2;
    assign oVALID  = r_s2_ok;
    assign oX      = r_x2;
    assign oY      = r_y2;
`endif

    assign oRed   = w_r_fin[DATA_W-1 -: OUT_W];
    assign oGreen = w_g_fin[DATA_W-1 -: OUT_W];
    assign oBlue  = w_b_fin[DATA_W-1 -: OUT_W];

    // Low channel bits, the dropped green LSBs and the stage-2 accept flag
    // (only needed with gain) are intentionally discarded.
    logic w_unused;
    assign w_unused = ^{w_r_fin, w_g_fin, w_b_fin, w_gsum_a[0], w_gsum_b[0], r_s2_acc};

endmodule

// File: tb/tb_raw2rgb_demosaic.sv
// -----------------------------------------------------------------------------
// tb_raw2rgb_demosaic
// Four instances of raw2rgb_demosaic, one per Bayer phase, share one input
// stream. A predictor keeps the received image in coordinate-indexed storage
// and derives each expected RGB pixel from the colour of the four kernel
// sites; a monitor pops the expected queue whenever an output is valid.
// Honours RAW2RGB_WB_GAIN_EN (fixed gains, latency 3).
// -----------------------------------------------------------------------------
module tb_raw2rgb_demosaic;

    localparam int DW   = 10;
    localparam int OW   = 8;
    localparam int AW   = 640;
    localparam int XW   = 10;
    localparam int VMIN = 3;
    localparam int VMAX = AW - 3;
`ifdef RAW2RGB_WB_GAIN_EN
    localparam int LAT  = 3;
    localparam int GR   = 80;
    localparam int GB   = 200;
`else
    localparam int LAT  = 2;
`endif

    localparam int K_FLAT = 0;
    localparam int K_SITE = 1;
    localparam int K_GAVG = 2;
    localparam int K_RAND = 3;

    typedef struct packed {
        logic [31:0]      issue;
        logic [XW-1:0]    x;
        logic [10:0]      y;
        logic [3:0][23:0] rgb;
    } exp_t;
    localparam int QW = $bits(exp_t);

    logic [QW-1:0] exp_q[$];

    // ---------------- clock / reset / DUTs ----------------
    logic          clk;
    logic          rst;
    logic          ivalid;
    logic          isof;
    logic [DW-1:0] idata;

    logic [OW-1:0] o_r [4];
    logic [OW-1:0] o_g [4];
    logic [OW-1:0] o_b [4];
    logic          o_v [4];
    logic [XW-1:0] o_x [4];
    logic [10:0]   o_y [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar p = 0; p < 4; p++) begin : g_ph
        raw2rgb_demosaic #(
            .BAYER_PHASE (2'(p))
        ) u_dut (
            .VGA_CLK (clk),
            .RST     (rst),
            .iDATA   (idata),
            .iVALID  (ivalid),
            .iSOF    (isof),
`ifdef RAW2RGB_WB_GAIN_EN
            .iGAIN_R (8'(GR)),
            .iGAIN_B (8'(GB)),
`endif
            .oRed    (o_r[p]),
            .oGreen  (o_g[p]),
            .oBlue   (o_b[p]),
            .oVALID  (o_v[p]),
            .oX      (o_x[p]),
            .oY      (o_y[p])
        );
    end

    int n_vec;
    int n_err;
    int n_valid;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] img [int];
    int            mx;
    int            my;
    int unsigned   cyc;

    // 0 = red, 3 = blue, 1/2 = green for a given CFA phase.
    function automatic int site(input int ph, input int y, input int x);
        return (((y & 1) ^ ((ph >> 1) & 1)) << 1) | ((x & 1) ^ (ph & 1));
    endfunction

    function automatic int px_at(input int y, input int x);
        if (img.exists(y * AW + x)) return int'(img[y * AW + x]);
        return 0;
    endfunction

    function automatic logic [23:0] model_rgb(input int ph, input int y, input int x);
        int r;
        int b;
        int gs;
        int v;
        int g;
        r  = 0;
        b  = 0;
        gs = 0;
        for (int dy = 0; dy < 2; dy++) begin
            for (int dx = 0; dx < 2; dx++) begin
                v = px_at(y - dy, x - dx);
                case (site(ph, y - dy, x - dx))
                    0:       r = v;
                    3:       b = v;
                    default: gs += v;
                endcase
            end
        end
        g = gs / 2;
`ifdef RAW2RGB_WB_GAIN_EN
        r = r * GR / 64;
        b = b * GB / 64;
        if (r > (1 << DW) - 1) r = (1 << DW) - 1;
        if (b > (1 << DW) - 1) b = (1 << DW) - 1;
`endif
        return {8'(r >> (DW - OW)), 8'(g >> (DW - OW)), 8'(b >> (DW - OW))};
    endfunction

    function automatic int pix(input int kind, input int ph, input int y, input int x);
        int s;
        s = site(ph, y, x);
        case (kind)
            K_FLAT: return 'h3FC;
            K_SITE: return (s == 0) ? 100 : (s == 3) ? 300 : 200;
            K_GAVG: return (s == 1 || s == 2) ? (((y & 1) == 0) ? 1023 : 0)
                                              : int'($urandom_range(0, 1023));
            default: return int'($urandom_range(0, 1023));
        endcase
    endfunction

    // Predictor: sees each accepted pixel at the sampling edge.
    initial begin
        int   px;
        int   py;
        exp_t e;
        cyc = 0;
        mx  = 0;
        my  = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                mx = 0;
                my = 0;
                img.delete();
            end else if (ivalid) begin
                px = isof ? 0 : mx;
                py = isof ? 0 : my;
                if (isof) img.delete();
                img[py * AW + px] = idata;
                if (py >= 1 && px > VMIN && px < VMAX) begin
                    e.issue = cyc;
                    e.x     = XW'(px);
                    e.y     = 11'(py);
                    for (int p = 0; p < 4; p++) e.rgb[p] = model_rgb(p, py, px);
                    exp_q.push_back(QW'(e));
                end
                if (px == AW - 1) begin
                    mx = 0;
                    my = (py < 2047) ? py + 1 : 2047;
                end else begin
                    mx = px + 1;
                    my = py;
                end
            end
            cyc++;
        end
    end

    // Monitor: compares every valid output against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_v[0] === 1'b1) n_valid++;
            if (o_v[0] === 1'b1 || o_v[1] === 1'b1 || o_v[2] === 1'b1 || o_v[3] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", {o_v[3], o_v[2], o_v[1], o_v[0]}, 0);
                end else begin
                    e = exp_t'(exp_q.pop_front());
                    check("latency", cyc - e.issue, LAT);
                    check("ox", o_x[0], e.x);
                    check("oy", o_y[0], e.y);
                    for (int p = 0; p < 4; p++) begin
                        check($sformatf("valid_ph%0d", p), o_v[p], 1);
                        check($sformatf("red_ph%0d", p),   o_r[p], e.rgb[p][23:16]);
                        check($sformatf("green_ph%0d", p), o_g[p], e.rgb[p][15:8]);
                        check($sformatf("blue_ph%0d", p),  o_b[p], e.rgb[p][7:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic s);
        @(negedge clk);
        ivalid = v;
        idata  = d;
        isof   = s;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, DW'($urandom_range(0, 1023)), 1'b0);
    endtask

    task automatic send_frame(input int kind, input int ph, input int start, input int stop,
                              input bit gaps, input int stall_x, input bit sof_en);
        int y;
        int x;
        for (int i = start; i < stop; i++) begin
            y = i / AW;
            x = i % AW;
            if (gaps && $urandom_range(0, 15) == 0) idle(int'($urandom_range(1, 3)));
            if (x == stall_x) idle(5);
            drive(1'b1, DW'(pix(kind, ph, y, x)), sof_en && (i == 0));
        end
    endtask

    task automatic flush();
        idle(1);
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) idle(1);
        idle(LAT + 1);
        check("queue_drained", exp_q.size(), 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int v0;
        n_vec   = 0;
        n_err   = 0;
        n_valid = 0;
        rst     = 1'b1;
        ivalid  = 1'b0;
        isof    = 1'b0;
        idata   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_red",    o_r[0], 0);
        check("reset_green",  o_g[0], 0);
        check("reset_blue",   o_b[0], 0);
        check("reset_valid",  o_v[0], 0);
        check("reset_x",      o_x[0], 0);
        check("reset_y",      o_y[0], 0);

        // Flat field: 3 valid lines of 633 pixels.
        v0 = n_valid;
        send_frame(K_FLAT, 0, 0, 4 * AW, 1'b0, -1, 1'b1);
        flush();
        check("flat_valid_count", n_valid - v0, 3 * (VMAX - VMIN - 1));

        // Per-site constant frames for every phase pattern.
        for (int ph = 0; ph < 4; ph++) begin
            send_frame(K_SITE, ph, 0, 3 * AW, 1'b0, -1, 1'b1);
            flush();
        end

        // Greens of 1023 and 0 in every kernel.
        send_frame(K_GAVG, 0, 0, 2 * AW, 1'b0, -1, 1'b1);
        flush();

        // Random data, random gaps, 5-cycle stall at X=300 on every line.
        send_frame(K_RAND, 0, 0, 4 * AW, 1'b1, 300, 1'b1);
        flush();

        // Start of frame in the middle of line 2.
        send_frame(K_RAND, 0, 0, 2 * AW + 100, 1'b0, -1, 1'b1);
        drive(1'b1, DW'($urandom_range(0, 1023)), 1'b1);
        drive(1'b0, '0, 1'b0);
        repeat (LAT - 1) @(negedge clk);
        check("sof_x", o_x[0], 0);
        check("sof_y", o_y[0], 0);
        send_frame(K_RAND, 0, 1, 2 * AW + 50, 1'b0, -1, 1'b0);
        flush();

        // Reset mid-line.
        send_frame(K_RAND, 0, 0, AW + 200, 1'b0, -1, 1'b1);
        flush();
        @(negedge clk);
        rst    = 1'b1;
        ivalid = 1'b1;
        idata  = DW'($urandom_range(0, 1023));
        @(negedge clk);
        rst    = 1'b0;
        ivalid = 1'b0;
        check("mid_rst_red",   o_r[0], 0);
        check("mid_rst_green", o_g[0], 0);
        check("mid_rst_blue",  o_b[0], 0);
        check("mid_rst_valid", o_v[0], 0);
        check("mid_rst_x",     o_x[0], 0);
        check("mid_rst_y",     o_y[0], 0);
        v0 = n_valid;
        send_frame(K_RAND, 0, 0, AW, 1'b0, -1, 1'b0);
        idle(LAT + 2);
        check("rst_first_line_valid", n_valid - v0, 0);
        send_frame(K_RAND, 0, AW, 2 * AW, 1'b0, -1, 1'b0);
        flush();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5ms;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
